// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: two-master, one-slave AXI3 read arbiter, one burst in flight, R routed by grant.
// Define AXI3_RD_ARB_QOS_EN to let the larger ARQOS win contention in IDLE.
module axi3_rd_arbiter #(
   parameter int N_BYTES = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int ID_WIDTH = 4,
   localparam int IW = (ID_WIDTH < 1) ? 1 : ID_WIDTH,
   localparam int DW = 8 * N_BYTES
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [IW-1:0]         m0_arid,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [3:0]            m0_arlen,
   input  logic [1:0]            m0_arsize,
   input  logic [1:0]            m0_arburst,
   input  logic [1:0]            m0_arlock,
   input  logic [3:0]            m0_arcache,
   input  logic [2:0]            m0_arprot,
   input  logic [3:0]            m0_arqos,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [IW-1:0]         m0_rid,
   output logic [DW-1:0]         m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rlast,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   input  logic [IW-1:0]         m1_arid,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [3:0]            m1_arlen,
   input  logic [1:0]            m1_arsize,
   input  logic [1:0]            m1_arburst,
   input  logic [1:0]            m1_arlock,
   input  logic [3:0]            m1_arcache,
   input  logic [2:0]            m1_arprot,
   input  logic [3:0]            m1_arqos,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [IW-1:0]         m1_rid,
   output logic [DW-1:0]         m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rlast,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   output logic [IW-1:0]         s_arid,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [3:0]            s_arlen,
   output logic [1:0]            s_arsize,
   output logic [1:0]            s_arburst,
   output logic [1:0]            s_arlock,
   output logic [3:0]            s_arcache,
   output logic [2:0]            s_arprot,
   output logic [3:0]            s_arqos,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [IW-1:0]         s_rid,
   input  logic [DW-1:0]         s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nxt;
   logic grant, last, win, ast, dst;
   // Handshakes are masked during reset so no beat or address completes in that cycle.
   assign ast = (state == ADDR) && !areset;
   assign dst = (state == DATA) && !areset;
`ifdef AXI3_RD_ARB_QOS_EN
   assign win = !m0_arvalid ? 1'b1 : !m1_arvalid ? 1'b0 :
                (m0_arqos > m1_arqos) ? 1'b0 : (m1_arqos > m0_arqos) ? 1'b1 : ~last;
`else
   assign win = !m0_arvalid ? 1'b1 : !m1_arvalid ? 1'b0 : ~last;
`endif
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? ((m0_arvalid || m1_arvalid) ? ADDR : IDLE) :
                  (state == ADDR) ? ((s_arvalid && s_arready) ? DATA : ADDR) :
                  ((s_rvalid && s_rready && s_rlast) ? IDLE : DATA);
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (m0_arvalid || m1_arvalid)) begin
            grant <= win;
            last  <= win;
         end
      end
   end
   assign s_arid     = ast ? (grant ? m1_arid    : m0_arid)    : '0;
   assign s_araddr   = ast ? (grant ? m1_araddr  : m0_araddr)  : '0;
   assign s_arlen    = ast ? (grant ? m1_arlen   : m0_arlen)   : '0;
   assign s_arsize   = ast ? (grant ? m1_arsize  : m0_arsize)  : '0;
   assign s_arburst  = ast ? (grant ? m1_arburst : m0_arburst) : '0;
   assign s_arlock   = ast ? (grant ? m1_arlock  : m0_arlock)  : '0;
   assign s_arcache  = ast ? (grant ? m1_arcache : m0_arcache) : '0;
   assign s_arprot   = ast ? (grant ? m1_arprot  : m0_arprot)  : '0;
   assign s_arqos    = ast ? (grant ? m1_arqos   : m0_arqos)   : '0;
   assign s_arvalid  = ast && (grant ? m1_arvalid : m0_arvalid);
   assign m0_arready = ast && !grant && s_arready;
   assign m1_arready = ast && grant && s_arready;
   assign s_rready   = dst && (grant ? m1_rready : m0_rready);
   assign m0_rvalid  = dst && !grant && s_rvalid;
   assign m1_rvalid  = dst && grant && s_rvalid;
   assign m0_rid     = s_rid;
   assign m0_rdata   = s_rdata;
   assign m0_rresp   = s_rresp;
   assign m0_rlast   = s_rlast;
   assign m1_rid     = s_rid;
   assign m1_rdata   = s_rdata;
   assign m1_rresp   = s_rresp;
   assign m1_rlast   = s_rlast;
   assign busy       = state != IDLE;
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed bench with an R-beat scoreboard for axi3_rd_arbiter.
module tb_axi3_rd_arbiter;
   logic aclk = 1'b0, areset = 1'b0;
   logic        arvalid[2], rready[2];
   logic [3:0]  arid[2], arlen[2], arqos[2];
   logic [11:0] araddr[2];
   logic        arready[2], rvalid[2], rlast[2];
   logic [3:0]  rid[2];
   logic [31:0] rdata[2];
   logic [1:0]  rresp[2];
   logic [3:0]  s_arid, s_arlen, s_arcache, s_arqos, s_rid;
   logic [11:0] s_araddr;
   logic [1:0]  s_arsize, s_arburst, s_arlock, s_rresp;
   logic [2:0]  s_arprot;
   logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, busy;
   logic [31:0] s_rdata;
   int n_tests = 0, n_fail = 0;
   typedef struct {int m; logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} beat_t;
   beat_t sb[$];

   always #5 aclk = ~aclk;

   axi3_rd_arbiter dut (
      .aclk(aclk), .areset(areset),
      .m0_arid(arid[0]), .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arsize(2'b10),
      .m0_arburst(2'b01), .m0_arlock(2'b00), .m0_arcache(4'h0), .m0_arprot(3'h0),
      .m0_arqos(arqos[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
      .m0_rid(rid[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]),
      .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
      .m1_arid(arid[1]), .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arsize(2'b10),
      .m1_arburst(2'b01), .m1_arlock(2'b00), .m1_arcache(4'h0), .m1_arprot(3'h0),
      .m1_arqos(arqos[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
      .m1_rid(rid[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]),
      .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
      .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .busy(busy)
   );

`define CHK(tag, obs, exp) begin n_tests++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: got %0h expected %0h", tag, (obs), (exp)); end end

   task automatic do_reset();
      @(negedge aclk); areset = 1'b1;
      @(negedge aclk); areset = 1'b0;
      #1;
   endtask

   task automatic check_idle(input string tag);
      `CHK({tag, "_busy"}, busy, 1'b0)
      `CHK({tag, "_s_arvalid"}, s_arvalid, 1'b0)
      `CHK({tag, "_s_araddr"}, s_araddr, 12'h0)
      `CHK({tag, "_s_rready"}, s_rready, 1'b0)
      `CHK({tag, "_arready0"}, arready[0], 1'b0)
      `CHK({tag, "_arready1"}, arready[1], 1'b0)
      `CHK({tag, "_rvalid0"}, rvalid[0], 1'b0)
      `CHK({tag, "_rvalid1"}, rvalid[1], 1'b0)
   endtask

   // Serve one burst for expected winner m; drop: 0 keep requests, 1 drop winner, 2 drop both.
   task automatic serve(input int m, input int drop, input int stall_at, input int stall_n, input int abort_at);
      int k, i, st, o, len;
      logic stall;
      logic [11:0] saddr;
      logic [3:0] sid;
      beat_t e;
      o = 1 - m;
      len = int'(arlen[m]);
      k = 0;
      do begin
         @(negedge aclk); s_rvalid = 1'b0; #1; k++;
      end while (!s_arvalid && k < 20);
      `CHK("ar_latency", k, 1)
      `CHK("s_araddr", s_araddr, araddr[m])
      `CHK("s_arid", s_arid, arid[m])
      `CHK("s_arlen", s_arlen, arlen[m])
      `CHK("arready_win", arready[m], 1'b1)
      `CHK("arready_lose", arready[o], 1'b0)
      `CHK("busy_addr", busy, 1'b1)
      saddr = s_araddr;
      sid = s_arid;
      for (int b = 0; b <= len; b++)
         sb.push_back('{m, arid[m], {araddr[m], 4'(b), 16'hbeef}, 2'(b), b == len});
      i = 0; st = 0; k = 0;
      while (i <= len && k < 200) begin
         @(negedge aclk); k++;
         if (drop == 1) arvalid[m] = 1'b0;
         if (drop == 2) begin arvalid[0] = 1'b0; arvalid[1] = 1'b0; end
         s_rvalid = 1'b1;
         s_rdata = {saddr, 4'(i), 16'hbeef};
         s_rid = sid;
         s_rresp = 2'(i);
         s_rlast = (i == len);
         stall = (i == stall_at) && (st < stall_n);
         if (stall) st++;
         rready[m] = !stall;
         areset = (i == abort_at);
         #1;
         n_tests++;
         if (rvalid[o] !== 1'b0) begin n_fail++; $error("FAIL rvalid_lose: got %0h expected 0", rvalid[o]); end
         if (areset) begin
            `CHK("abort_s_rready", s_rready, 1'b0)
            `CHK("abort_rvalid", rvalid[m], 1'b0)
            @(negedge aclk); areset = 1'b0; #1;
            check_idle("after_abort");
            s_rvalid = 1'b0;
            sb.delete();
            return;
         end
         n_tests++;
         if (rvalid[m] !== 1'b1) begin n_fail++; $error("FAIL rvalid_win: got %0h expected 1", rvalid[m]); end
         n_tests++;
         if (s_rready !== rready[m]) begin n_fail++; $error("FAIL s_rready: got %0h expected %0h", s_rready, rready[m]); end
         if (rready[m]) begin
            `CHK("sb_nonempty", sb.size() > 0, 1'b1)
            if (sb.size() > 0) begin
               e = sb.pop_front();
               `CHK("beat_master", m, e.m)
               `CHK("rdata", rdata[m], e.data)
               `CHK("rid", rid[m], e.id)
               `CHK("rresp", rresp[m], e.resp)
               `CHK("rlast", rlast[m], e.last)
            end
            i++;
         end
      end
      `CHK("beats_done", i, len + 1)
      // A stray slave beat in the IDLE cycle must be back-pressured.
      @(negedge aclk);
      s_rvalid = 1'b1; s_rlast = 1'b1; rready[m] = 1'b1;
      #1;
      `CHK("busy_after_last", busy, 1'b0)
      `CHK("stray_s_rready", s_rready, 1'b0)
      `CHK("stray_rvalid0", rvalid[0], 1'b0)
      `CHK("stray_rvalid1", rvalid[1], 1'b0)
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      arvalid = '{1'b0, 1'b0}; rready = '{1'b1, 1'b1};
      arid = '{4'h1, 4'h2}; arlen = '{4'h3, 4'h1}; arqos = '{4'h0, 4'h0};
      araddr = '{12'h010, 12'h200};
      s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h7; s_rdata = 32'hdead_0000; s_rresp = 2'b00;
      do_reset();
      check_idle("reset");
      // m0 alone, ARLEN=3
      @(negedge aclk); arvalid[0] = 1'b1; #1;
      `CHK("t1_s_arvalid_T", s_arvalid, 1'b0)
      serve(0, 1, -1, 0, -1);
      // simultaneous from reset: m0 first, then m1
      do_reset();
      araddr = '{12'h100, 12'h200}; arlen = '{4'h2, 4'h1};
      @(negedge aclk); arvalid = '{1'b1, 1'b1};
      serve(0, 1, -1, 0, -1);
      serve(1, 1, -1, 0, -1);
      // continuous contention: 0,1,0,1,0,1
      araddr = '{12'h3a0, 12'h4b0}; arlen = '{4'h1, 4'h2};
      @(negedge aclk); arvalid = '{1'b1, 1'b1};
      for (int n = 0; n < 6; n++) serve(n % 2, (n == 5) ? 2 : 0, -1, 0, -1);
      // m1 stalls RREADY for 5 cycles on beat 1
      araddr[1] = 12'h5c4; arlen[1] = 4'h3;
      @(negedge aclk); arvalid[1] = 1'b1;
      serve(1, 1, 1, 5, -1);
      // reset during beat 2 of an ARLEN=7 burst, then m1 granted normally
      araddr[0] = 12'h6d8; arlen[0] = 4'h7;
      @(negedge aclk); arvalid[0] = 1'b1;
      serve(0, 1, -1, 0, 2);
      arvalid[0] = 1'b0;
      araddr[1] = 12'h7e0; arlen[1] = 4'h1;
      @(negedge aclk); arvalid[1] = 1'b1;
      serve(1, 1, -1, 0, -1);
`ifdef AXI3_RD_ARB_QOS_EN
      do_reset();
      arqos = '{4'd2, 4'd9}; araddr = '{12'h810, 12'h920};
      @(negedge aclk); arvalid = '{1'b1, 1'b1};
      serve(1, 1, -1, 0, -1);
      serve(0, 1, -1, 0, -1);
      do_reset();
      arqos = '{4'd5, 4'd5};
      @(negedge aclk); arvalid = '{1'b1, 1'b1};
      for (int n = 0; n < 6; n++) serve(n % 2, (n == 5) ? 2 : 0, -1, 0, -1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi3_rd_arbiter.md
# axi3_rd_arbiter

Two-master, one-slave read-channel arbiter for the AXI3 bus. It shares a single downstream read port (AR and R channels) between two upstream masters, typically a DMA engine and a CPU port in front of one memory controller. It allows one burst in flight at a time and routes R beats back by grant rather than by ID. Write channels are outside this block's scope.

## Interface
- N_BYTES, 4, bytes per data beat (RDATA = 8*N_BYTES bits)
- ADDR_WIDTH, 12, AR address width
- ID_WIDTH, 4, ID width; values < 1 are clamped to 1 bit

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset; synchronous, active-high
- mN_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARVALID  in  ID/ADDR/4/2/2/2/4/3/4/1  read address from master N (N = 0, 1)
- mN_ARREADY  out  1  address accept to master N
- mN_RID/RDATA/RRESP/RLAST/RVALID  out  ID/8*N_BYTES/2/1/1  read data to master N
- mN_RREADY  in  1  read data accept from master N
- s_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARVALID  out  same widths  read address to slave
- s_ARREADY  in  1  slave address accept
- s_RID/RDATA/RRESP/RLAST/RVALID  in  same widths  read data from slave
- s_RREADY  out  1  read data accept to slave
- busy  out  1  high in ADDR or DATA state

## Operation
- FSM states: IDLE, ADDR, DATA. `grant` is a 1-bit register. `last` is the 1-bit index of the master granted most recently.
- IDLE: if any mN_ARVALID is high, register `grant` and go to ADDR.
  - Both masters requesting: the master != `last` wins.
  - Only one requesting: that master wins.
  - On grant, `last` <= the winner.
- ADDR: all s_AR* payload is driven combinationally from the granted master.
  - s_ARVALID = m[grant]_ARVALID.
  - m[grant]_ARREADY = s_ARREADY; the other master's ARREADY = 0.
  - When s_ARVALID & s_ARREADY, go to DATA.
- DATA: s_R* is forwarded to m[grant].
  - m[grant]_RVALID = s_RVALID; s_RREADY = m[grant]_RREADY.
  - The non-granted master sees RVALID = 0. Its RDATA/RID/RRESP/RLAST mirror the slave bus and must be treated as don't-care.
  - On s_RVALID & s_RREADY & s_RLAST, go to IDLE.
- Outside DATA, s_RREADY = 0 and both mN_RVALID = 0. Stray slave beats are back-pressured, not dropped.
- IDs pass through unmodified in both directions. Routing uses `grant`, not RID.
- Masters must hold ARVALID and payload stable until ARREADY (AXI rule). Withdrawing ARVALID in ADDR is illegal; the block stays in ADDR until it is reasserted and accepted.
- ARLEN is not counted. Burst end is RLAST only.

## Timing
- Reset values: state = IDLE, `grant` = 0, `last` = 1 (so master 0 wins the first contention).
  - All outputs after reset: mN_ARREADY = 0, mN_RVALID = 0, s_ARVALID = 0, s_RREADY = 0, busy = 0.
  - All s_AR* payload outputs = 0 in IDLE.
- ARESET asserted mid-burst aborts the burst. The next cycle is IDLE with the reset values above; no beat completes in the reset cycle.
- Arbitration latency:
  - ARVALID seen in IDLE in cycle T drives s_ARVALID high in cycle T+1.
  - The earliest AR handshake is T+1.
- R path is combinational: zero added latency.
- After the RLAST handshake in cycle T, the block is IDLE in T+1. The next grant is decided in T+1, and the next s_ARVALID rises in T+2.
- Throughput: one burst per (burst length + 2) cycles minimum.
- Simultaneous new requests in IDLE are resolved by the round-robin rule only; no starvation.

## Configuration
- AXI3_RD_ARB_QOS_EN defined:
  - In IDLE with both masters requesting, the master with the strictly larger ARQOS (unsigned 4-bit) wins.
  - On equal ARQOS, the round-robin rule applies.
  - `last` updates identically.
- Not defined: pure round-robin; ARQOS is forwarded but ignored for arbitration.

## Test plan
- Reset, then m0 alone issues ARADDR=0x010, ARLEN=3 -> s_ARVALID rises 1 cycle later with ARADDR=0x010; 4 R beats reach m0 only; busy drops the cycle after RLAST.
- m0 and m1 request together from reset -> m0 (ARID=1) served first, then m1 (ARID=2); m1's RVALID stays 0 during m0's burst.
- Both masters request continuously for 6 bursts -> grants alternate 0,1,0,1,0,1.
- m1 holds RREADY=0 for 5 cycles mid-burst -> s_RREADY=0 for those cycles; RDATA is not lost; beat order is preserved.
- ARESET for one cycle during DATA beat 2 of an ARLEN=7 burst -> all outputs take reset values the next cycle; next request from m1 is granted normally.
- With AXI3_RD_ARB_QOS_EN: m0 ARQOS=2, m1 ARQOS=9, simultaneous -> m1 wins; with equal ARQOS=5 -> round-robin order as in the 6-burst test.
